// File: rtl/cache_controller_burst_if.sv
// CPU/system-bus/SRAM-control bundle for the burst cache controller.
// master = CPU pipeline and bus environment, slave = the controller.
interface cache_controller_burst_if #(
  parameter int WORDSPERLINE     = 4,
  parameter int BLOCKOFFSETWIDTH = 2,
  parameter int INDEXWIDTH       = 6,
  parameter int BYTESPERWORD     = 4
);
  logic                        Pstrobe;
  logic                        Prw;
  logic [BYTESPERWORD-1:0]     store_type;
  logic                        isHit;
  logic [INDEXWIDTH-1:0]       addr_index;
  logic [BLOCKOFFSETWIDTH-1:0] block_offset;
  logic                        stall;
  logic                        SYSready;
  logic                        flush_req;

  logic                        Pready;
  logic                        SYSstrobe;
  logic                        SYSrw;
  logic                        pdataOE;
  logic                        sysdataOE;
  logic                        cs_tag;
  logic                        oe_tag;
  logic                        web_tag;
  logic                        cs_valid;
  logic                        oe_valid;
  logic                        web_valid;
  logic                        valid_wdata;
  logic                        cs_data;
  logic                        oe_data;
  logic [BYTESPERWORD-1:0]     web_data;
  logic                        sel_dataarray_in;
  logic [WORDSPERLINE-1:0]     sel_dataunit_in;
  logic [BLOCKOFFSETWIDTH-1:0] sel_dataunit_out;
  logic [INDEXWIDTH-1:0]       array_index;
  logic                        flush_done;

  modport master (
    output Pstrobe, Prw, store_type, isHit, addr_index, block_offset,
           stall, SYSready, flush_req,
    input  Pready, SYSstrobe, SYSrw, pdataOE, sysdataOE,
           cs_tag, oe_tag, web_tag, cs_valid, oe_valid, web_valid, valid_wdata,
           cs_data, oe_data, web_data, sel_dataarray_in, sel_dataunit_in,
           sel_dataunit_out, array_index, flush_done
  );

  modport slave (
    input  Pstrobe, Prw, store_type, isHit, addr_index, block_offset,
           stall, SYSready, flush_req,
    output Pready, SYSstrobe, SYSrw, pdataOE, sysdataOE,
           cs_tag, oe_tag, web_tag, cs_valid, oe_valid, web_valid, valid_wdata,
           cs_data, oe_data, web_data, sel_dataarray_in, sel_dataunit_in,
           sel_dataunit_out, array_index, flush_done
  );
endinterface

// File: rtl/cache_controller_burst.sv
// Direct-mapped write-through, no-write-allocate L1 controller with counted
// line-refill bursts, registered write-hit decision and a flush sweep.
module cache_controller_burst #(
  parameter int WORDSPERLINE     = 4,
  parameter int BLOCKOFFSETWIDTH = 2,
  parameter int INDEXWIDTH       = 6,
  parameter int BYTESPERWORD     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  cache_controller_burst_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_READMEM, S_WRITEMEM, S_DONE, S_FLUSH
  } state_t;

  localparam logic [BLOCKOFFSETWIDTH-1:0] LAST_BEAT = BLOCKOFFSETWIDTH'(WORDSPERLINE - 1);
  localparam logic [INDEXWIDTH-1:0]       LAST_SET  = '1;
  localparam logic [WORDSPERLINE-1:0]     ONE_WORD  = WORDSPERLINE'(1);

  state_t                      state, state_nx;
  logic [BLOCKOFFSETWIDTH-1:0] beat_cnt;
  logic [INDEXWIDTH-1:0]       flush_idx;
  logic                        hit_q;

  logic beat_step;
  logic flush_step;
  logic hit_load;

  assign beat_step  = (state == S_READMEM) && bus.SYSready;
  assign flush_step = (state == S_FLUSH);
  assign hit_load   = (state == S_IDLE) && !bus.flush_req && bus.Pstrobe && bus.Prw;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      beat_cnt  <= '0;
      flush_idx <= '0;
      hit_q     <= 1'b0;
    end else begin
      state <= state_nx;
      if (beat_step)  beat_cnt  <= beat_cnt + 1'b1;
      if (flush_step) flush_idx <= flush_idx + 1'b1;
      if (hit_load)   hit_q     <= bus.isHit;
    end
  end

  assign bus.sel_dataunit_out = bus.block_offset;
  assign bus.array_index      = (state == S_FLUSH) ? flush_idx : bus.addr_index;

  always_comb begin
    // NOTE: every output and the next state get their IDLE value first, so no
    // branch can leave one unassigned and infer a latch.
    state_nx             = state;
    bus.Pready           = 1'b0;
    bus.SYSstrobe        = 1'b0;
    bus.SYSrw            = 1'b0;
    bus.pdataOE          = 1'b1;
    bus.sysdataOE        = 1'b0;
    bus.cs_tag           = bus.Pstrobe;
    bus.oe_tag           = bus.Pstrobe;
    bus.web_tag          = 1'b1;
    bus.cs_valid         = bus.Pstrobe;
    bus.oe_valid         = bus.Pstrobe;
    bus.web_valid        = 1'b1;
    bus.valid_wdata      = 1'b0;
    bus.cs_data          = 1'b1;
    bus.oe_data          = 1'b1;
    bus.web_data         = '1;
    bus.sel_dataarray_in = 1'b0;
    bus.sel_dataunit_in  = '0;
    bus.flush_done       = 1'b0;

    case (state)
      S_IDLE: begin
        if (bus.flush_req) begin
          state_nx = S_FLUSH;
        end else if (bus.Pstrobe) begin
          if (bus.Prw) begin
            bus.SYSstrobe = 1'b1;
            bus.SYSrw     = 1'b1;
            state_nx      = S_WRITEMEM;
          end else if (bus.isHit) begin
            bus.Pready = 1'b1;
          end else begin
            bus.SYSstrobe = 1'b1;
            state_nx      = S_READMEM;
          end
        end
      end

      S_READMEM: begin
        bus.SYSstrobe = 1'b1;
        bus.pdataOE   = 1'b0;
        if (bus.SYSready) begin
          bus.sel_dataunit_in = ONE_WORD << beat_cnt;
          bus.web_data        = '0;
          // The line only becomes valid once its last word has landed.
          if (beat_cnt == LAST_BEAT) begin
            bus.cs_tag      = 1'b1;
            bus.cs_valid    = 1'b1;
            bus.web_tag     = 1'b0;
            bus.web_valid   = 1'b0;
            bus.valid_wdata = 1'b1;
            state_nx        = S_DONE;
          end
        end
      end

      S_WRITEMEM: begin
        bus.SYSstrobe        = 1'b1;
        bus.SYSrw            = 1'b1;
        bus.sysdataOE        = 1'b1;
        bus.pdataOE          = 1'b0;
        bus.sel_dataarray_in = 1'b1;
        bus.sel_dataunit_in  = ONE_WORD << bus.block_offset;
        if (bus.SYSready) begin
          if (hit_q) bus.web_data = bus.store_type;
          state_nx = S_DONE;
        end
      end

      S_DONE: begin
        bus.Pready = 1'b1;
        if (!bus.stall) state_nx = S_IDLE;
      end

      S_FLUSH: begin
        bus.cs_valid    = 1'b1;
        bus.web_valid   = 1'b0;
        bus.valid_wdata = 1'b0;
        if (flush_idx == LAST_SET) begin
          bus.flush_done = 1'b1;
          state_nx       = S_IDLE;
        end
      end

      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_controller_burst.sv
// Randomized transaction-level bench for cache_controller_burst; expected
// per-cycle outputs come from the transaction rules, not the RTL structure.
module tb_cache_controller_burst;
  localparam int W  = 4;
  localparam int BO = 2;
  localparam int IW = 6;
  localparam int BW = 4;
  localparam int SETS = 1 << IW;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  cache_controller_burst_if #(.WORDSPERLINE(W), .BLOCKOFFSETWIDTH(BO),
                              .INDEXWIDTH(IW), .BYTESPERWORD(BW)) ifc ();

  cache_controller_burst #(.WORDSPERLINE(W), .BLOCKOFFSETWIDTH(BO),
                           .INDEXWIDTH(IW), .BYTESPERWORD(BW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    ifc.Pstrobe    = 1'b0;
    ifc.Prw        = 1'b0;
    ifc.isHit      = 1'b0;
    ifc.stall      = 1'b0;
    ifc.SYSready   = 1'b0;
    ifc.flush_req  = 1'b0;
    ifc.store_type = '1;
  endtask

  // One idle cycle: nothing pending, stray SYSready must be ignored.
  task automatic idle_cycle(input string tag);
    idle_inputs();
    ifc.SYSready   = 1'($urandom);
    ifc.addr_index = IW'($urandom);
    sample();
    check({tag, ".Pready"},    32'(ifc.Pready),     32'd0);
    check({tag, ".SYSstrobe"}, 32'(ifc.SYSstrobe),  32'd0);
    check({tag, ".pdataOE"},   32'(ifc.pdataOE),    32'd1);
    check({tag, ".web_valid"}, 32'(ifc.web_valid),  32'd1);
    check({tag, ".web_data"},  32'(ifc.web_data),   32'hF);
    check({tag, ".flush_done"},32'(ifc.flush_done), 32'd0);
    check({tag, ".array_idx"}, 32'(ifc.array_index),32'(ifc.addr_index));
    step();
  endtask

  // The DONE phase: Pready held through `stall_cycles` stalled cycles plus one release cycle.
  task automatic done_phase(input int stall_cycles);
    for (int s = 0; s <= stall_cycles; s++) begin
      ifc.stall    = (s < stall_cycles);
      ifc.SYSready = 1'($urandom);
      ifc.Pstrobe  = 1'b0;
      sample();
      check("done.Pready",    32'(ifc.Pready),    32'd1);
      check("done.SYSstrobe", 32'(ifc.SYSstrobe), 32'd0);
      check("done.pdataOE",   32'(ifc.pdataOE),   32'd1);
      check("done.web_data",  32'(ifc.web_data),  32'hF);
      check("done.web_tag",   32'(ifc.web_tag),   32'd1);
      step();
    end
    idle_cycle("after_done");
  endtask

  task automatic read_hit();
    idle_inputs();
    ifc.Pstrobe      = 1'b1;
    ifc.isHit        = 1'b1;
    ifc.addr_index   = IW'($urandom);
    ifc.block_offset = BO'($urandom);
    sample();
    check("rhit.Pready",    32'(ifc.Pready),           32'd1);
    check("rhit.SYSstrobe", 32'(ifc.SYSstrobe),        32'd0);
    check("rhit.sel_out",   32'(ifc.sel_dataunit_out), 32'(ifc.block_offset));
    step();
    idle_cycle("rhit_idle");
  endtask

  // Read miss; bit j of ready_pat is SYSready in the j-th refill cycle, forced high past bit 15.
  task automatic read_miss(input logic [15:0] ready_pat, input int stall_cycles, input bit noisy_flush);
    int k;
    int j;
    int lat;
    bit rdy;
    logic [IW-1:0] idx;
    idle_inputs();
    idx              = IW'($urandom);
    ifc.Pstrobe      = 1'b1;
    ifc.addr_index   = idx;
    ifc.block_offset = BO'($urandom);
    sample();
    check("rmiss.req.SYSstrobe", 32'(ifc.SYSstrobe), 32'd1);
    check("rmiss.req.SYSrw",     32'(ifc.SYSrw),     32'd0);
    check("rmiss.req.Pready",    32'(ifc.Pready),    32'd0);
    step();
    k = 0;
    j = 0;
    lat = 1;
    while (k < W) begin
      rdy = (j < 16) ? ready_pat[j] : 1'b1;
      ifc.SYSready  = rdy;
      ifc.isHit     = 1'($urandom);
      ifc.stall     = (stall_cycles > 0);
      ifc.flush_req = noisy_flush ? 1'($urandom) : 1'b0;
      sample();
      check("rmiss.SYSstrobe", 32'(ifc.SYSstrobe), 32'd1);
      check("rmiss.SYSrw",     32'(ifc.SYSrw),     32'd0);
      check("rmiss.pdataOE",   32'(ifc.pdataOE),   32'd0);
      check("rmiss.sel_arr",   32'(ifc.sel_dataarray_in), 32'd0);
      check("rmiss.Pready",    32'(ifc.Pready),    32'd0);
      check("rmiss.array_idx", 32'(ifc.array_index), 32'(idx));
      if (rdy) begin
        check("rmiss.sel_in",    32'(ifc.sel_dataunit_in), 32'(1 << k));
        check("rmiss.web_data",  32'(ifc.web_data),  32'h0);
        check("rmiss.web_tag",   32'(ifc.web_tag),   (k == W - 1) ? 32'd0 : 32'd1);
        check("rmiss.web_valid", 32'(ifc.web_valid), (k == W - 1) ? 32'd0 : 32'd1);
        check("rmiss.valid_wd",  32'(ifc.valid_wdata),(k == W - 1) ? 32'd1 : 32'd0);
        k++;
      end else begin
        check("rmiss.gap.sel_in",   32'(ifc.sel_dataunit_in), 32'd0);
        check("rmiss.gap.web_data", 32'(ifc.web_data), 32'hF);
        check("rmiss.gap.web_tag",  32'(ifc.web_tag),  32'd1);
      end
      step();
      j++;
      lat++;
    end
    ifc.SYSready  = 1'b0;
    ifc.flush_req = 1'b0;
    if (ready_pat == 16'hFFFF) check("rmiss.latency", 32'(lat), 32'(1 + W));
    done_phase(stall_cycles);
  endtask

  task automatic write_txn(input bit hit, input int gaps, input int stall_cycles);
    logic [BO-1:0] off;
    logic [BW-1:0] st;
    off = BO'($urandom);
    st  = BW'($urandom);
    idle_inputs();
    ifc.Pstrobe      = 1'b1;
    ifc.Prw          = 1'b1;
    ifc.isHit        = hit;
    ifc.block_offset = off;
    ifc.store_type   = st;
    ifc.addr_index   = IW'($urandom);
    sample();
    check("wr.req.SYSstrobe", 32'(ifc.SYSstrobe), 32'd1);
    check("wr.req.SYSrw",     32'(ifc.SYSrw),     32'd1);
    check("wr.req.Pready",    32'(ifc.Pready),    32'd0);
    step();
    ifc.isHit = ~hit;
    for (int g = 0; g <= gaps; g++) begin
      ifc.SYSready  = (g == gaps);
      ifc.stall     = (stall_cycles > 0);
      ifc.flush_req = 1'($urandom);
      sample();
      check("wr.SYSstrobe", 32'(ifc.SYSstrobe), 32'd1);
      check("wr.SYSrw",     32'(ifc.SYSrw),     32'd1);
      check("wr.sysdataOE", 32'(ifc.sysdataOE), 32'd1);
      check("wr.pdataOE",   32'(ifc.pdataOE),   32'd0);
      check("wr.sel_arr",   32'(ifc.sel_dataarray_in), 32'd1);
      check("wr.sel_in",    32'(ifc.sel_dataunit_in),  32'(1 << off));
      check("wr.Pready",    32'(ifc.Pready),    32'd0);
      if (g == gaps) check("wr.web_data", 32'(ifc.web_data), hit ? 32'(st) : 32'hF);
      else           check("wr.gap.web_data", 32'(ifc.web_data), 32'hF);
      step();
    end
    ifc.SYSready  = 1'b0;
    ifc.flush_req = 1'b0;
    done_phase(stall_cycles);
  endtask

  // Flush sweep; a read hit issued mid-sweep must only be answered back in IDLE.
  task automatic flush_txn();
    int mid;
    idle_inputs();
    ifc.flush_req = 1'b1;
    ifc.Pstrobe   = 1'($urandom);
    ifc.isHit     = 1'b1;
    sample();
    check("flush.req.Pready",    32'(ifc.Pready),    32'd0);
    check("flush.req.SYSstrobe", 32'(ifc.SYSstrobe), 32'd0);
    step();
    idle_inputs();
    mid = 8 + int'($urandom_range(40));
    for (int i = 0; i < SETS; i++) begin
      if (i == mid) begin
        ifc.Pstrobe = 1'b1;
        ifc.Prw     = 1'b0;
        ifc.isHit   = 1'b1;
      end
      ifc.SYSready   = 1'($urandom);
      ifc.addr_index = IW'($urandom);
      sample();
      check("flush.web_valid",  32'(ifc.web_valid),   32'd0);
      check("flush.cs_valid",   32'(ifc.cs_valid),    32'd1);
      check("flush.valid_wd",   32'(ifc.valid_wdata), 32'd0);
      check("flush.array_idx",  32'(ifc.array_index), 32'(i));
      check("flush.flush_done", 32'(ifc.flush_done),  (i == SETS - 1) ? 32'd1 : 32'd0);
      check("flush.Pready",     32'(ifc.Pready),      32'd0);
      check("flush.SYSstrobe",  32'(ifc.SYSstrobe),   32'd0);
      step();
    end
    ifc.SYSready = 1'b0;
    sample();
    check("flush.after.Pready",     32'(ifc.Pready),     32'd1);
    check("flush.after.flush_done", 32'(ifc.flush_done), 32'd0);
    check("flush.after.web_valid",  32'(ifc.web_valid),  32'd1);
    step();
    idle_cycle("flush_idle");
  endtask

  // Reset asserted for two cycles on the third refill beat.
  task automatic reset_mid_refill();
    idle_inputs();
    ifc.Pstrobe    = 1'b1;
    ifc.addr_index = IW'($urandom);
    step();
    ifc.Pstrobe  = 1'b0;
    ifc.SYSready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      sample();
      check("rst.pre.sel_in", 32'(ifc.sel_dataunit_in), 32'(1 << b));
      step();
    end
    rst = 1'b1;
    sample();
    check("rst.beat2.sel_in", 32'(ifc.sel_dataunit_in), 32'(1 << 2));
    step();
    sample();
    check("rst.SYSstrobe", 32'(ifc.SYSstrobe), 32'd0);
    check("rst.Pready",    32'(ifc.Pready),    32'd0);
    check("rst.web_tag",   32'(ifc.web_tag),   32'd1);
    check("rst.web_valid", 32'(ifc.web_valid), 32'd1);
    check("rst.web_data",  32'(ifc.web_data),  32'hF);
    check("rst.sel_in",    32'(ifc.sel_dataunit_in), 32'd0);
    step();
    rst = 1'b0;
    idle_inputs();
    idle_cycle("rst_idle");
    // A fresh refill must start from word 0 again.
    read_miss(16'hFFFF, 0, 1'b0);
  endtask

  initial begin
    int kind;
    idle_inputs();
    ifc.addr_index   = '0;
    ifc.block_offset = '0;
    rst = 1'b1;
    step();
    step();
    sample();
    check("init.Pready",     32'(ifc.Pready),          32'd0);
    check("init.SYSstrobe",  32'(ifc.SYSstrobe),       32'd0);
    check("init.SYSrw",      32'(ifc.SYSrw),           32'd0);
    check("init.sysdataOE",  32'(ifc.sysdataOE),       32'd0);
    check("init.pdataOE",    32'(ifc.pdataOE),         32'd1);
    check("init.web_tag",    32'(ifc.web_tag),         32'd1);
    check("init.web_valid",  32'(ifc.web_valid),       32'd1);
    check("init.web_data",   32'(ifc.web_data),        32'hF);
    check("init.sel_in",     32'(ifc.sel_dataunit_in), 32'd0);
    check("init.valid_wd",   32'(ifc.valid_wdata),     32'd0);
    check("init.flush_done", 32'(ifc.flush_done),      32'd0);
    check("init.cs_oe_data", 32'({ifc.cs_data, ifc.oe_data}), 32'h3);
    check("init.oe_tag",     32'(ifc.oe_tag),          32'd0);
    step();
    rst = 1'b0;

    read_miss(16'hFFFF, 0, 1'b0);
    read_miss(16'h004D, 0, 1'b0);
    write_txn(1'b1, 0, 0);
    write_txn(1'b0, 0, 0);
    read_miss(16'hFFFF, 3, 1'b0);
    read_hit();
    flush_txn();
    reset_mid_refill();

    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(9));
      case (kind)
        0, 1:    read_hit();
        2, 3, 4: read_miss(16'($urandom), int'($urandom_range(3)), 1'b1);
        5, 6:    write_txn(1'b1, int'($urandom_range(3)), int'($urandom_range(2)));
        7, 8:    write_txn(1'b0, int'($urandom_range(3)), int'($urandom_range(2)));
        default: flush_txn();
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
